// File: rtl/hilo_muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide engine feeding the HiLo register pair.
// Optional MADD/MSUB accumulate path enabled by defining MULDIV_MADD_EN.
`timescale 1ns/1ps
module hilo_muldiv_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [63:0] HiLoIn,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic        HiLoWriteEnable,
    output logic [63:0] HiLoWriteData
);

    typedef enum logic [1:0] {IDLE, ITER, FIXUP, WRITE} state_t;

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
`ifdef MULDIV_MADD_EN
    localparam logic [2:0] OP_MADD = 3'd4;
    localparam logic [2:0] OP_MSUB = 3'd5;
`endif

    state_t      state;
    logic [4:0]  iterCnt;
    logic        isDivReg;
    logic        negQuot;
    logic        negRem;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic [31:0] opB;
`ifdef MULDIV_MADD_EN
    logic        maddReg;
    logic        msubReg;
    logic signed [63:0] hiLoCap;
`else
    logic        unusedHiLoIn;
    assign unusedHiLoIn = ^HiLoIn;
`endif

    logic        signedOp;
    logic        isDivOp;
    logic        legalOp;
    logic [32:0] mulSum;
    logic [32:0] divShift;
    logic [33:0] divDiff;
    logic signed [63:0] prodSigned;
    logic [63:0] fixResult;

    function automatic logic [31:0] absVal(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [31:0] negIf32(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] negIf64(input logic [63:0] x, input logic neg);
        return neg ? (~x + 64'd1) : x;
    endfunction

    always_comb begin
        isDivOp  = (Op == OP_DIV) || (Op == OP_DIVU);
`ifdef MULDIV_MADD_EN
        legalOp  = (Op <= OP_MSUB);
        signedOp = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
`else
        legalOp  = (Op <= OP_DIVU);
        signedOp = (Op == OP_MULT) || (Op == OP_DIV);
`endif
    end

    // One radix-2 step: multiply adds the multiplicand into Hi and shifts {carry,Hi,Lo} right;
    // divide shifts the next dividend bit into the partial remainder and trial-subtracts.
    always_comb begin
        mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, opB} : 33'd0);
        divShift = {hiReg, loReg[31]};
        divDiff  = {1'b0, divShift} - {2'b00, opB};
    end

    always_comb begin
        prodSigned = signed'(negIf64({hiReg, loReg}, negQuot));
        fixResult  = prodSigned;
        if (isDivReg) begin
            fixResult = {negIf32(hiReg, negRem), negIf32(loReg, negQuot)};
        end
`ifdef MULDIV_MADD_EN
        else if (maddReg) begin
            fixResult = hiLoCap + prodSigned;
        end else if (msubReg) begin
            fixResult = hiLoCap - prodSigned;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= IDLE;
            iterCnt         <= 5'd0;
            Busy            <= 1'b0;
            Done            <= 1'b0;
            DivByZero       <= 1'b0;
            HiLoWriteEnable <= 1'b0;
            HiLoWriteData   <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        Busy <= 1'b1;
                        if (!legalOp || (isDivOp && (B == 32'd0))) begin
                            // Fast path: completion pulse only, HiLo untouched.
                            state     <= WRITE;
                            Done      <= 1'b1;
                            DivByZero <= legalOp && isDivOp;
                        end else begin
                            state    <= ITER;
                            iterCnt  <= 5'd0;
                            isDivReg <= isDivOp;
                            negQuot  <= signedOp && (A[31] ^ B[31]);
                            negRem   <= signedOp && A[31];
                            hiReg    <= 32'd0;
                            loReg    <= absVal(A, signedOp);
                            opB      <= absVal(B, signedOp);
`ifdef MULDIV_MADD_EN
                            maddReg  <= (Op == OP_MADD);
                            msubReg  <= (Op == OP_MSUB);
                            hiLoCap  <= signed'(HiLoIn);
`endif
                        end
                    end
                end
                ITER: begin
                    iterCnt <= iterCnt + 5'd1;
                    if (isDivReg) begin
                        hiReg <= divDiff[33] ? divShift[31:0] : divDiff[31:0];
                        loReg <= {loReg[30:0], ~divDiff[33]};
                    end else begin
                        hiReg <= mulSum[32:1];
                        loReg <= {mulSum[0], loReg[31:1]};
                    end
                    if (iterCnt == 5'd31) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    HiLoWriteData   <= fixResult;
                    HiLoWriteEnable <= 1'b1;
                    Done            <= 1'b1;
                    state           <= WRITE;
                end
                WRITE: begin
                    HiLoWriteEnable <= 1'b0;
                    Done            <= 1'b0;
                    DivByZero       <= 1'b0;
                    Busy            <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
